// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Build option DMEM_ARB_EXT_PRIO_EN switches the picker to fixed external priority.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } owner_e;

  localparam int LAT_W = 4;

  // Request/grant vectors use bit 0 for the core and bit 1 for the external port.
  localparam int REQ_CORE = 0;
  localparam int REQ_EXT  = 1;

  function automatic owner_e winner_of(input logic [1:0] gnt);
    return gnt[REQ_EXT] ? OWN_EXT : OWN_CORE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way picker: round-robin by default, fixed external
// priority when DMEM_ARB_EXT_PRIO_EN is defined.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_i,
  output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_EXT_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[REQ_EXT]) begin
      gnt_o[REQ_EXT] = 1'b1;
    end else if (req_i[REQ_CORE]) begin
      gnt_o[REQ_CORE] = 1'b1;
    end
  end
`else
  // NOTE: every path assigns gnt_o first, so no latch can be inferred.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == OWN_EXT) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core and an external loader/debug port.
// Optional macro DMEM_ARB_EXT_PRIO_EN: external port always wins ties.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              PCrst,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  owner_e           owner_q, owner_d;
  owner_e           rr_last_q, rr_last_d;

  logic [1:0] req_vec;
  logic [1:0] gnt_vec;
  logic       grant_any;
  logic       win_ext;
  logic       win_we;
  logic       rsp_fire;

  // Requests are masked while reset is held so every output stays quiet.
  assign req_vec   = PCrst ? 2'b00 : {ext_req, core_req};
  assign grant_any = (state_q == IDLE) && (gnt_vec != 2'b00);
  assign win_ext   = gnt_vec[REQ_EXT];
  assign win_we    = win_ext ? ext_we : core_we;
  assign rsp_fire  = (state_q == RD_WAIT) && (lat_cnt_q == LAT_W'(1));

  rr_arb2 u_rr_arb2 (
    .req_i  (req_vec),
    .last_i (rr_last_q),
    .gnt_o  (gnt_vec)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk or posedge PCrst) begin
    if (PCrst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      owner_q   <= OWN_CORE;
      rr_last_q <= OWN_EXT;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          rr_last_d = winner_of(gnt_vec);
          // Writes retire at the grant edge; only reads occupy the port.
          if (!win_we) begin
            state_d   = RD_WAIT;
            owner_d   = winner_of(gnt_vec);
            lat_cnt_d = LAT_W'(MEM_LAT);
          end
        end
      end
      RD_WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_gnt    = 1'b0;
    ext_gnt     = 1'b0;
    core_rvalid = 1'b0;
    ext_rvalid  = 1'b0;
    core_rdata  = '0;
    ext_rdata   = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          core_gnt  = gnt_vec[REQ_CORE];
          ext_gnt   = gnt_vec[REQ_EXT];
          mem_en    = 1'b1;
          mem_we    = win_we;
          mem_addr  = win_ext ? ext_addr  : core_addr;
          mem_wdata = win_ext ? ext_wdata : core_wdata;
        end
      end
      RD_WAIT: begin
        if (rsp_fire) begin
          if (owner_q == OWN_CORE) begin
            core_rvalid = 1'b1;
            core_rdata  = mem_rdata;
          end else begin
            ext_rvalid = 1'b1;
            ext_rdata  = mem_rdata;
          end
        end
      end
      default: ;
    endcase
    // Freeze the core while it waits for a grant or for its own load data.
    core_stall = !PCrst &&
                 ((core_req && !core_gnt) ||
                  (core_gnt && !core_we) ||
                  (state_q == RD_WAIT && owner_q == OWN_CORE));
  end

endmodule
